// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit -- program counter with an optional return-address stack (RAS).
//
// Produces the fetch address for an in-order front end. The PC advances by one
// on every accepted fetch. It redirects to branch_target on branch_valid, and
// to the top of the return stack on ret. All outputs come straight from flops.
//
// Build option:
//   PC_RAS_EN  defined   -> a circular return stack of RAS_DEPTH entries.
//              undefined -> no stack storage. call and ret are ignored,
//                           ras_empty = 1, ras_full = 0, ras_underflow = 0.
//
// Parameters:
//   WIDTH      PC / target width in bits
//   RESET_PC   PC value loaded by reset
//   RAS_DEPTH  number of return-stack entries
//
// Ports:
//   clk            single clock, rising edge
//   rst_n          synchronous active-low reset
//   branch_valid   redirect to branch_target this cycle (highest priority)
//   branch_target  redirect address
//   call           with branch_valid: push pc+1 as a return address
//   ret            pop the return stack and jump there (ignored on branch_valid)
//   stall          hold the current PC
//   pc_ready       fetch stage accepts pc
//   pc_valid       pc is valid (drops only during reset)
//   pc             current fetch address
//   ras_empty      return stack holds no entries
//   ras_full       return stack holds RAS_DEPTH entries
//   ras_underflow  one-cycle pulse after a ret issued while the stack was empty
// -----------------------------------------------------------------------------
module pc_unit #(
  parameter int unsigned      WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned      RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             branch_valid,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             call,
  input  logic             ret,
  input  logic             stall,
  input  logic             pc_ready,
  output logic             pc_valid,
  output logic [WIDTH-1:0] pc,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_underflow
);

  // ---------------------------------------------------------------------------
  // PC datapath
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             pc_valid_q, pc_valid_d;
  logic [WIDTH-1:0] pc_inc;   // pc + 1; also the return address of a call
  logic             accept;   // fetch stage takes the current pc this cycle
  logic             do_pop;   // a ret that really redirects to the stack top
  logic [WIDTH-1:0] ras_top;  // return address at the top of the stack

  assign accept = pc_valid_q & pc_ready & ~stall;
  assign pc_inc = pc_q + WIDTH'(1);   // modulo 2^WIDTH: all-ones wraps to zero

  // Redirects (branch, then return) beat the sequential advance. They also
  // ignore pc_ready and stall, because the old fetch address is dead anyway.
  always_comb begin
    // NOTE: each always_comb output gets a default first. Then no path leaves it unassigned, and no latch is inferred.
    pc_d = pc_q;
    if (branch_valid) begin
      pc_d = branch_target;
    end else if (do_pop) begin
      pc_d = ras_top;
    end else if (accept) begin
      pc_d = pc_inc;
    end
  end

  // Once reset is gone the PC is always presentable. pc_valid therefore rises
  // at the first edge out of reset and holds at 1 from then on.
  always_comb begin
    pc_valid_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignment. All flops then sample pre-edge values, and no evaluation order races.
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      pc_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
    end
  end

  assign pc       = pc_q;
  assign pc_valid = pc_valid_q;

`ifdef PC_RAS_EN
  // ---------------------------------------------------------------------------
  // Return-address stack: a circular buffer with a top pointer and a count.
  // When the stack is full, the slot after the top holds the oldest entry.
  // A push while full therefore overwrites the oldest entry, and the count
  // stays saturated.
  // ---------------------------------------------------------------------------
  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] top_q, top_d;
  logic [PTR_W-1:0] push_ptr, pop_ptr;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ras_empty_q, ras_empty_d;
  logic             ras_full_q, ras_full_d;
  logic             ras_underflow_q, ras_underflow_d;
  logic             do_push;

  // A push and a pop cannot happen in the same cycle. A push needs
  // branch_valid, and a pop needs it low (a branch always suppresses ret).
  assign do_push = branch_valid & call;
  assign do_pop  = ret & ~branch_valid & ~ras_empty_q;

  // Pointer steps wrap explicitly, so RAS_DEPTH need not be a power of two.
  assign push_ptr = (top_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : top_q + PTR_W'(1);
  assign pop_ptr  = (top_q == '0) ? PTR_W'(RAS_DEPTH - 1) : top_q - PTR_W'(1);

  assign ras_top = ras_mem[top_q];

  always_comb begin
    top_d = top_q;
    cnt_d = cnt_q;
    if (do_push) begin
      top_d = push_ptr;
      cnt_d = ras_full_q ? cnt_q : cnt_q + CNT_W'(1);
    end else if (do_pop) begin
      top_d = pop_ptr;
      cnt_d = cnt_q - CNT_W'(1);
    end
    // The flags are registered from the next count, so they describe the
    // occupancy right after each edge.
    ras_empty_d     = (cnt_d == '0);
    ras_full_d      = (cnt_d == CNT_W'(RAS_DEPTH));
    // A ret on an empty stack is dropped, but it raises a flag for one cycle.
    ras_underflow_d = ret & ~branch_valid & ras_empty_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      top_q           <= '0;
      cnt_q           <= '0;
      ras_empty_q     <= 1'b1;
      ras_full_q      <= 1'b0;
      ras_underflow_q <= 1'b0;
    end else begin
      top_q           <= top_d;
      cnt_q           <= cnt_d;
      ras_empty_q     <= ras_empty_d;
      ras_full_q      <= ras_full_d;
      ras_underflow_q <= ras_underflow_d;
    end
  end

  // NOTE: the entry storage has no reset. Validity comes only from cnt_q, so clearing the data would add logic and do nothing.
  always_ff @(posedge clk) begin
    if (rst_n && do_push) begin
      ras_mem[push_ptr] <= pc_inc;
    end
  end

  assign ras_empty     = ras_empty_q;
  assign ras_full      = ras_full_q;
  assign ras_underflow = ras_underflow_q;

`else
  // ---------------------------------------------------------------------------
  // No return stack. call/ret have no effect and the flags are constants.
  // ---------------------------------------------------------------------------
  logic unused_ras;
  assign unused_ras = &{1'b0, call, ret, RAS_DEPTH[0]};

  assign do_pop        = 1'b0;
  assign ras_top       = '0;
  assign ras_empty     = 1'b1;
  assign ras_full      = 1'b0;
  assign ras_underflow = 1'b0;
`endif

endmodule
